// File: rtl/lb_match_ctrl_if.sv
// Pixel/line-buffer/SAD bus between the frame scan controller and its neighbours.
// master: thresholding stage + SAD side; slave: lb_match_ctrl.
interface lb_match_ctrl_if #(
  parameter int SAD_W = 12
);
  logic             pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic             lb_d;
  logic             lb_ena;
  logic [SAD_W-1:0] sad_in;

  modport master (
    output pix_in, pix_valid, sad_in,
    input  pix_ready, lb_d, lb_ena
  );

  modport slave (
    input  pix_in, pix_valid, sad_in,
    output pix_ready, lb_d, lb_ena
  );
endinterface

// File: rtl/lb_match_ctrl.sv
// Frame scan controller: fills the line buffer, walks template origins, keeps the raster-earliest SAD minimum.
// Optional LB_MATCH_EARLY_EXIT_EN: a sampled zero SAD ends the scan immediately.
module lb_match_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TPL_W   = 40,
  parameter int TPL_H   = 100,
  parameter int SAD_W   = 12,
  parameter int SAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  lb_match_ctrl_if.slave           bus,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(IMG_W)-1:0] best_x,
  output logic [$clog2(IMG_H)-1:0] best_y,
  output logic [SAD_W-1:0]         best_sad
);
  localparam int X_W    = $clog2(IMG_W);
  localparam int Y_W    = $clog2(IMG_H);
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int PIX_W  = $clog2(N_PIX);
  localparam int PIPE_D = (SAD_LAT > 0) ? SAD_LAT : 1;
  localparam int LAT_W  = (SAD_LAT > 1) ? $clog2(SAD_LAT) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(N_PIX - 1);
  localparam logic [X_W-1:0]   COL_MAX    = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0]   COL_LAST   = X_W'(IMG_W - TPL_W);
  localparam logic [Y_W-1:0]   ROW_LAST   = Y_W'(IMG_H - TPL_H);
  localparam logic [LAT_W-1:0] DRAIN_INIT = LAT_W'((SAD_LAT > 0) ? SAD_LAT - 1 : 0);

  //  state   | meaning
  //  S_IDLE  | waiting for start after reset
  //  S_FILL  | accepting thresholded pixels into the line buffer
  //  S_SCAN  | shifting zeros, issuing one origin tag per legal column
  //  S_DRAIN | tag pipe emptying, no more shifts
  //  S_DONE  | result stable, waiting for start
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [PIX_W-1:0]           pix_cnt_q, pix_cnt_d;
  logic [X_W-1:0]             col_q, col_d;
  logic [Y_W-1:0]             row_q, row_d;
  logic [LAT_W-1:0]           drain_q, drain_d;
  logic [X_W-1:0]             best_x_q, best_x_d;
  logic [Y_W-1:0]             best_y_q, best_y_d;
  logic [SAD_W-1:0]           best_sad_q, best_sad_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       pix_ready_q, pix_ready_d;
  logic [PIPE_D-1:0]          tag_v_q, tag_v_d;
  logic [PIPE_D-1:0][X_W-1:0] tag_x_q, tag_x_d;
  logic [PIPE_D-1:0][Y_W-1:0] tag_y_q, tag_y_d;

  logic           tag_now_v;
  logic           out_v;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;

  assign tag_now_v = (state_q == S_SCAN) && (col_q <= COL_LAST);
  // With zero latency the SAD belongs to the origin being issued right now.
  assign out_v = (SAD_LAT == 0) ? tag_now_v : tag_v_q[PIPE_D-1];
  assign out_x = (SAD_LAT == 0) ? col_q     : tag_x_q[PIPE_D-1];
  assign out_y = (SAD_LAT == 0) ? row_q     : tag_y_q[PIPE_D-1];

  assign bus.pix_ready = pix_ready_q;
  assign bus.lb_ena    = ((state_q == S_FILL) && bus.pix_valid) || (state_q == S_SCAN);
  assign bus.lb_d      = (state_q == S_FILL) ? bus.pix_in : 1'b0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_x        = best_x_q;
  assign best_y        = best_y_q;
  assign best_sad      = best_sad_q;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    drain_d    = drain_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    best_sad_d = best_sad_q;

    tag_v_d[0] = tag_now_v;
    tag_x_d[0] = col_q;
    tag_y_d[0] = row_q;
    for (int i = 1; i < PIPE_D; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_x_d[i] = tag_x_q[i-1];
      tag_y_d[i] = tag_y_q[i-1];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FILL;
          pix_cnt_d  = '0;
          col_d      = '0;
          row_d      = '0;
          drain_d    = '0;
          best_x_d   = '0;
          best_y_d   = '0;
          best_sad_d = '1;
          tag_v_d    = '0;
        end
      end
      S_FILL: begin
        if (bus.pix_valid) begin
          if (pix_cnt_q == PIX_LAST) begin
            state_d   = S_SCAN;
            pix_cnt_d = '0;
            col_d     = '0;
            row_d     = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end
      S_SCAN: begin
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = row_q + Y_W'(1);
        end else begin
          col_d = col_q + X_W'(1);
        end
        if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
          state_d = (SAD_LAT == 0) ? S_DONE : S_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - LAT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Strict compare so ties keep the raster-earlier origin.
    if (out_v && (bus.sad_in < best_sad_q)) begin
      best_sad_d = bus.sad_in;
      best_x_d   = out_x;
      best_y_d   = out_y;
    end

`ifdef LB_MATCH_EARLY_EXIT_EN
    if (out_v && (bus.sad_in == '0)) begin
      state_d = S_DONE;
      tag_v_d = '0;
    end
`endif

    busy_d      = (state_d == S_FILL) || (state_d == S_SCAN) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    pix_ready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      best_sad_q  <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      tag_v_q     <= '0;
      tag_x_q     <= '0;
      tag_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      best_sad_q  <= best_sad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_ready_q <= pix_ready_d;
      tag_v_q     <= tag_v_d;
      tag_x_q     <= tag_x_d;
      tag_y_q     <= tag_y_d;
    end
  end
endmodule

// File: tb/tb_lb_match_ctrl.sv
// Randomized bench for lb_match_ctrl on a small 8x6 image with a 2x3 template.
// Expected best origin and completion cycle come from a raster-order minimum search over a SAD map.
module tb_lb_match_ctrl;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 6;
  localparam int TPL_W   = 2;
  localparam int TPL_H   = 3;
  localparam int SAD_W   = 4;
  localparam int SAD_LAT = 1;
  localparam int N_PIX   = IMG_W * IMG_H;
  localparam int K_LAST  = (IMG_H - TPL_H) * IMG_W + (IMG_W - TPL_W);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done;
  logic [2:0] best_x;
  logic [2:0] best_y;
  logic [SAD_W-1:0] best_sad;

  lb_match_ctrl_if #(.SAD_W(SAD_W)) bus ();

  lb_match_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL_W(TPL_W), .TPL_H(TPL_H),
    .SAD_W(SAD_W), .SAD_LAT(SAD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .best_x(best_x), .best_y(best_y), .best_sad(best_sad)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sad_map [N_PIX];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raster-order search; a zero ends the walk only when early exit is built in.
  task automatic model(output int ex, output int ey, output int es, output int ed);
    es = 15; ex = 0; ey = 0;
    ed = K_LAST + 1 + SAD_LAT;
    for (int k = 0; k <= K_LAST; k++) begin
      if ((k % IMG_W) > (IMG_W - TPL_W)) continue;
      if (sad_map[k] < es) begin
        es = sad_map[k];
        ex = k % IMG_W;
        ey = k / IMG_W;
      end
`ifdef LB_MATCH_EARLY_EXIT_EN
      if (sad_map[k] == 0) begin
        ed = k + SAD_LAT + 1;
        break;
      end
`endif
    end
  endtask

  task automatic fill_map(input int v);
    for (int k = 0; k < N_PIX; k++) sad_map[k] = v;
  endtask

  task automatic rand_map();
    for (int k = 0; k < N_PIX; k++) begin
      sad_map[k] = $urandom_range(1, 15);
      if ($urandom_range(0, 39) == 0) sad_map[k] = 0;
    end
  endtask

  task automatic run_frame(input bit inj_start, input int abort_at);
    int acc, guard, k, done_at, ex, ey, es, ed;
    model(ex, ey, es, ed);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    check("reinit_sad", best_sad, 15);
    check("reinit_x", best_x, 0);
    check("reinit_y", best_y, 0);
    acc = 0;
    guard = 0;
    while (acc < N_PIX && guard < 1000) begin
      bus.pix_valid = ($urandom_range(0, 3) != 0);
      bus.pix_in    = 1'($urandom);
      bus.sad_in    = SAD_W'($urandom);
      start         = inj_start && ($urandom_range(0, 7) == 0);
      #1;
      check("fill_ready", bus.pix_ready, 1);
      check("fill_lb_ena", bus.lb_ena, bus.pix_valid);
      if (bus.pix_valid) check("fill_lb_d", bus.lb_d, bus.pix_in);
      check("fill_busy", busy, 1);
      if (bus.pix_valid) acc++;
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    check("fill_accepts", acc, N_PIX);
    done_at = -1;
    for (int c = 0; c < 200; c++) begin
      k = c - SAD_LAT;
      bus.sad_in    = (k >= 0 && k <= K_LAST) ? SAD_W'(sad_map[k]) : SAD_W'($urandom_range(0, 15));
      bus.pix_valid = 1'($urandom);
      bus.pix_in    = 1'($urandom);
      start         = inj_start && (c < ed) && ($urandom_range(0, 5) == 0);
      #1;
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sad", best_sad, 15);
        check("abort_x", best_x, 0);
        check("abort_lb_ena", bus.lb_ena, 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ready", bus.pix_ready, 0);
        check("idle_sad", best_sad, 15);
        return;
      end
      if (done) begin
        done_at = c;
        break;
      end
      check("scan_lb_ena", bus.lb_ena, (c <= K_LAST) ? 1 : 0);
      check("scan_lb_d", bus.lb_d, 0);
      check("scan_ready", bus.pix_ready, 0);
      check("scan_busy", busy, 1);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_cycle", done_at, ed);
    check("best_x", best_x, ex);
    check("best_y", best_y, ey);
    check("best_sad", best_sad, es);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sad_in    = SAD_W'($urandom);
      bus.pix_valid = 1'($urandom);
      #1;
      check("done_hold", done, 1);
      check("done_busy", busy, 0);
      check("done_lb_ena", bus.lb_ena, 0);
      check("hold_sad", best_sad, es);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.pix_in = 1'b0;
    bus.pix_valid = 1'b0;
    bus.sad_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", bus.pix_ready, 0);
    check("rst_lb_ena", bus.lb_ena, 0);
    check("rst_lb_d", bus.lb_d, 0);
    check("rst_sad", best_sad, 15);
    check("rst_x", best_x, 0);
    check("rst_y", best_y, 0);
    rst = 1'b0;

    fill_map(9);
    sad_map[2*IMG_W + 4] = 3;
    run_frame(1'b0, -1);

    fill_map(7);
    sad_map[0*IMG_W + 1] = 5;
    sad_map[3*IMG_W + 3] = 5;
    run_frame(1'b0, -1);

    rand_map();
    run_frame(1'b1, -1);

    fill_map(8);
    sad_map[1*IMG_W + 2] = 2;
    run_frame(1'b0, 20);
    rand_map();
    run_frame(1'b0, -1);

    rand_map();
    sad_map[1*IMG_W + 2] = 0;
    for (int k = 0; k < 1*IMG_W + 2; k++) if (sad_map[k] == 0) sad_map[k] = 4;
    run_frame(1'b0, -1);

    for (int f = 0; f < 4; f++) begin
      rand_map();
      run_frame(f[0], -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
